sha256_iter: RTL



---
 rtl/sha256_pkg.sv | 56 +++++
 rtl/sha256_iter_if.sv | 35 +++
 rtl/sha256_round.sv | 17 +
 rtl/sha256_iter.sv | 114 +++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants (IVs, round constants), FSM state type and word-level helper functions.
package sha256_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, UPDATE} state_t;
    typedef logic [0:7][31:0] words8_t;

    localparam words8_t IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam words8_t IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_iter_if.sv
// sha256_iter_if: block stream in / digest out bundle for sha256_iter.
// Carries the mode224 select only when SHA256_SHA224_MODE_EN is defined.
interface sha256_iter_if;

    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_in;
    logic         block_first;
    logic         block_last;
    logic         busy;
    logic         hash_valid;
    logic [255:0] hashed;
`ifdef SHA256_SHA224_MODE_EN
    logic         mode224;

    modport master (
        output block_valid, block_in, block_first, block_last, mode224,
        input  block_ready, busy, hash_valid, hashed
    );
    modport slave (
        input  block_valid, block_in, block_first, block_last, mode224,
        output block_ready, busy, hash_valid, hashed
    );
`else
    modport master (
        output block_valid, block_in, block_first, block_last,
        input  block_ready, busy, hash_valid, hashed
    );
    modport slave (
        input  block_valid, block_in, block_first, block_last,
        output block_ready, busy, hash_valid, hashed
    );
`endif

endinterface

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round over the working variables a..h.
module sha256_round
    import sha256_pkg::*;
(
    input  words8_t     i_s,
    input  logic [31:0] i_k,
    input  logic [31:0] i_w,
    output words8_t     o_s
);

    logic [31:0] w_t1, w_t2;

    assign w_t1 = i_s[7] + Sigma1(i_s[4]) + ch(i_s[4], i_s[5], i_s[6]) + i_k + i_w;
    assign w_t2 = Sigma0(i_s[0]) + maj(i_s[0], i_s[1], i_s[2]);
    assign o_s  = {w_t1 + w_t2, i_s[0], i_s[1], i_s[2], i_s[3] + w_t1, i_s[4], i_s[5], i_s[6]};

endmodule

// File: rtl/sha256_iter.sv
// sha256_iter: iterative SHA-256 compression engine, ROUNDS_PER_CYCLE rounds per clock, H kept across blocks.
// Defining SHA256_SHA224_MODE_EN adds the mode224 input (SHA-224 IV and truncated digest).
module sha256_iter
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input logic          clk,
    input logic          reset,
    sha256_iter_if.slave bus
);

    localparam int NCYC = 64 / ROUNDS_PER_CYCLE;
    localparam int NW = 16 + ROUNDS_PER_CYCLE;
    localparam logic [5:0] LAST_T = 6'((NCYC - 1) * ROUNDS_PER_CYCLE);

    state_t           r_state;
    logic [5:0]       r_t;
    words8_t          r_h, r_s;
    logic [0:15][31:0] r_w;
    logic             r_last;
    words8_t          w_base, w_hn, w_rs;
    logic [255:0]     w_dig;
    logic [0:NW-1][31:0] w_x;

    // Window words 0..R-1 feed this cycle's rounds; words R..R+15 become the next window.
    function automatic logic [0:NW-1][31:0] expand(input logic [0:15][31:0] w);
        logic [0:NW-1][31:0] x;
        x[0:15] = w;
        for (int i = 16; i < NW; i++)
            x[i] = sigma1(x[i-2]) + x[i-7] + sigma0(x[i-15]) + x[i-16];
        return x;
    endfunction

    assign w_x = expand(r_w);

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_rnd
        words8_t w_i, w_o;
        if (j == 0) begin : g_first
            assign w_i = r_s;
        end else begin : g_next
            assign w_i = g_rnd[j-1].w_o;
        end
        sha256_round u_rnd (.i_s(w_i), .i_k(K[r_t + 6'(j)]), .i_w(w_x[j]), .o_s(w_o));
    end

    assign w_rs = g_rnd[ROUNDS_PER_CYCLE-1].w_o;

    always_comb begin
        w_hn = r_h;
        for (int i = 0; i < 8; i++)
            w_hn[i] = r_h[i] + r_s[i];
    end

`ifdef SHA256_SHA224_MODE_EN
    logic r_m224;
    assign w_base = !bus.block_first ? r_h : bus.mode224 ? IV224 : IV256;
    assign w_dig  = r_m224 ? {w_hn[0:6], 32'h0} : w_hn;
`else
    assign w_base = bus.block_first ? IV256 : r_h;
    assign w_dig  = w_hn;
`endif

    assign bus.block_ready = r_state == IDLE;
    assign bus.busy        = r_state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_t            <= '0;
            r_h            <= '0;
            r_s            <= '0;
            r_w            <= '0;
            r_last         <= 1'b0;
            bus.hash_valid <= 1'b0;
            bus.hashed     <= '0;
`ifdef SHA256_SHA224_MODE_EN
            r_m224         <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (bus.block_valid) begin
                    r_w     <= bus.block_in;
                    r_h     <= w_base;
                    r_s     <= w_base;
                    r_last  <= bus.block_last;
                    r_t     <= '0;
                    r_state <= ROUND;
                    // A finished digest stays visible through chained (non-first) blocks.
                    if (bus.block_first) bus.hash_valid <= 1'b0;
`ifdef SHA256_SHA224_MODE_EN
                    if (bus.block_first) r_m224 <= bus.mode224;
`endif
                end
                ROUND: begin
                    r_s     <= w_rs;
                    r_w     <= w_x[ROUNDS_PER_CYCLE +: 16];
                    r_t     <= r_t + 6'(ROUNDS_PER_CYCLE);
                    r_state <= r_t == LAST_T ? UPDATE : ROUND;
                end
                UPDATE: begin
                    r_h     <= w_hn;
                    r_state <= IDLE;
                    if (r_last) begin
                        bus.hashed     <= w_dig;
                        bus.hash_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
